// File: rtl/filter_scan_ctrl.sv
// Shared consensus debounce engine: one channel per clock per prescaled sweep, DEPTH agreeing samples flip an output.
// Sweep latency NCH clocks; a busy event slot without accept stalls the sweep; ticks during a sweep set sticky overrun.
module filter_scan_ctrl #(
    parameter int NCH      = 4,
    parameter int IDXW     = 2,
    parameter int DEPTH    = 3,
    parameter int PRESCALE = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic [NCH-1:0]  i_sig_in,
    output logic [NCH-1:0]  o_sig_out,
    output logic            o_evt_valid,
    input  logic            i_evt_ready,
    output logic [IDXW-1:0] o_evt_chan,
    output logic            o_evt_level,
    input  logic            i_ovr_clr,
    output logic            o_overrun
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NCH-1:0]    r_sync1;
    logic [NCH-1:0]    r_sync2;
    logic [PCW-1:0]    r_pcnt;
    logic [IDXW-1:0]   r_idx;
    logic [DEPTH-1:0]  r_hist [NCH];
    logic [NCH-1:0]    r_sig_out;
    logic              r_evt_valid;
    logic [IDXW-1:0]   r_evt_chan;
    logic              r_evt_level;
    logic              r_overrun;

    logic              w_tick;
    logic [DEPTH-1:0]  w_hist_n;
    logic              w_cur_out;
    logic              w_set;
    logic              w_clr;
    logic              w_chg;
    logic              w_scan;
    logic              w_slot_free;
    logic              w_commit;
    logic              w_load;
    logic              w_last;

    assign w_tick      = i_enable && (r_pcnt == PCW'(PRESCALE - 1));
    assign w_scan      = (r_state == ST_SCAN);
    assign w_cur_out   = r_sig_out[r_idx];
    assign w_hist_n    = {r_hist[r_idx][DEPTH-2:0], r_sync2[r_idx]};
    assign w_set       = (&w_hist_n) & ~w_cur_out;
    assign w_clr       = ~(|w_hist_n) & w_cur_out;
    assign w_chg       = w_set | w_clr;
    // A slot being accepted this cycle counts as free, so accept and reload share a clock.
    assign w_slot_free = ~r_evt_valid | i_evt_ready;
    assign w_commit    = w_scan & (~w_chg | w_slot_free);
    assign w_load      = w_scan & w_chg & w_slot_free;
    assign w_last      = (r_idx == IDXW'(NCH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sig_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
        end else if (!i_enable || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PCW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_commit && w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= '0;
            r_sig_out   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_level <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            if (!w_scan && w_tick) begin
                r_idx <= '0;
            end else if (w_commit) begin
                r_idx <= w_last ? '0 : r_idx + IDXW'(1);
            end
            // A stalled channel keeps its old history so the retry sees a fresh sample.
            if (w_commit) begin
                r_hist[r_idx] <= w_hist_n;
            end
            if (w_load) begin
                r_sig_out[r_idx] <= ~w_cur_out;
                r_evt_valid      <= 1'b1;
                r_evt_chan       <= r_idx;
                r_evt_level      <= ~w_cur_out;
            end else if (r_evt_valid && i_evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_tick && w_scan) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_sig_out   = r_sig_out;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_chan  = r_evt_chan;
    assign o_evt_level = r_evt_level;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Scoreboarded bench: a sweep-level debounce model pushes expected events; a monitor pops on each handshake.
module tb_filter_scan_ctrl;
    localparam int NCH = 4;
    localparam int IDXW = 2;
    localparam int DEPTH = 3;
    localparam int PRESCALE = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b1;
    logic [NCH-1:0]  sig_in = '0;
    logic [NCH-1:0]  sig_out;
    logic            evt_valid;
    logic            evt_ready = 1'b1;
    logic [IDXW-1:0] evt_chan;
    logic            evt_level;
    logic            ovr_clr = 1'b0;
    logic            overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [IDXW:0]   exp_q[$];
    logic [NCH-1:0]  m_out;
    logic            m_last [NCH];
    int              m_run [NCH];
    logic            pv [1:8];
    logic [IDXW-1:0] pc [1:8];
    logic            pl [1:8];

    filter_scan_ctrl #(.NCH(NCH), .IDXW(IDXW), .DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sig_in(sig_in),
        .o_sig_out(sig_out), .o_evt_valid(evt_valid), .i_evt_ready(evt_ready),
        .o_evt_chan(evt_chan), .o_evt_level(evt_level), .i_ovr_clr(ovr_clr),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: got chan=%0d level=%0d, required no event", evt_chan, evt_level);
            end else begin
                logic [IDXW:0] e;
                e = exp_q.pop_front();
                if (e !== {evt_chan, evt_level}) begin
                    n_err++;
                    $display("FAIL evt_order: got chan=%0d level=%0d, required chan=%0d level=%0d",
                             evt_chan, evt_level, e[IDXW:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic m_reset();
        m_out = '0;
        for (int c = 0; c < NCH; c++) begin
            m_last[c] = 1'b0;
            m_run[c]  = DEPTH;
        end
    endtask

    // One sweep: a channel flips once its last DEPTH samples agree and differ from its output.
    task automatic model_sweep(input logic [NCH-1:0] vec);
        for (int c = 0; c < NCH; c++) begin
            if (vec[c] == m_last[c]) begin
                if (m_run[c] < DEPTH) m_run[c]++;
            end else begin
                m_last[c] = vec[c];
                m_run[c]  = 1;
            end
            if (m_run[c] == DEPTH && vec[c] != m_out[c]) begin
                m_out[c] = vec[c];
                exp_q.push_back({IDXW'(c), vec[c]});
            end
        end
    endtask

    task automatic do_reset(input logic [NCH-1:0] vec);
        check("queue_drained", exp_q.size(), 0);
        rst_n = 1'b0;
        enable = 1'b1;
        evt_ready = 1'b1;
        ovr_clr = 1'b0;
        sig_in = vec;
        #2;
        check("rst_sig_out", sig_out, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_chan", evt_chan, 0);
        check("rst_evt_level", evt_level, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        m_reset();
        repeat (4) step();
    endtask

    // Starts 4 clocks after a sweep begins; the sweep inside this window sees vec on every channel.
    task automatic period(input logic [NCH-1:0] vec, input bit rnd_ready);
        sig_in = vec;
        evt_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        model_sweep(vec);
        for (int j = 1; j <= 8; j++) begin
            step();
            pv[j] = evt_valid;
            pc[j] = evt_chan;
            pl[j] = evt_level;
            evt_ready = (rnd_ready && (cyc % 8) >= 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("sig_out_after_sweep", sig_out, m_out);
    endtask

    task automatic setup_stall(input logic [NCH-1:0] vec);
        do_reset(vec);
        evt_ready = 1'b0;
        repeat (24) step();
        check("stall_valid", evt_valid, 1);
        check("stall_chan", evt_chan, 0);
        check("stall_level", evt_level, 1);
        check("stall_sig_out", sig_out, 4'b0001);
        check("stall_no_ovr_yet", overrun, 0);
        repeat (8) step();
        check("stall_overrun", overrun, 1);
        check("stall_held_chan", evt_chan, 0);
        check("stall_held_valid", evt_valid, 1);
        check("stall_held_out", sig_out, 4'b0001);
    endtask

    initial begin
        logic [NCH-1:0] cur;
        #1;
        do_reset(4'b0001);
        for (int k = 0; k < 5; k++) period(4'b0001, 1'b0);

        period(4'b0011, 1'b0);
        period(4'b0011, 1'b0);
        for (int k = 0; k < 3; k++) period(4'b0001, 1'b0);
        check("glitch_suppressed", sig_out[1], 0);
        for (int k = 0; k < 3; k++) period(4'b0011, 1'b0);
        for (int k = 0; k < 3; k++) period(4'b0001, 1'b0);

        cur = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) cur = 4'($urandom);
            period(cur, 1'b1);
        end
        for (int k = 0; k < 4; k++) period(4'b1010, 1'b0);

        repeat (6) step();
        rst_n = 1'b0;
        #2;
        check("midsweep_rst_out", sig_out, 0);
        check("midsweep_rst_valid", evt_valid, 0);
        check("midsweep_rst_ovr", overrun, 0);

        do_reset(4'b0011);
        for (int k = 0; k < 3; k++) period(4'b0011, 1'b0);
        check("b2b_first_valid", pv[5], 1);
        check("b2b_first_chan", pc[5], 0);
        check("b2b_second_valid", pv[6], 1);
        check("b2b_second_chan", pc[6], 1);
        check("b2b_second_level", pl[6], 1);
        check("b2b_drained", pv[7], 0);

        setup_stall(4'b0101);
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd2, 1'b1});
        evt_ready = 1'b1;
        repeat (8) step();
        check("unstall_out", sig_out, 4'b0101);
        check("unstall_ovr_sticky", overrun, 1);
        check("unstall_valid", evt_valid, 0);

        setup_stall(4'b0101);
        rst_n = 1'b0;
        #2;
        check("midstall_rst_out", sig_out, 0);
        check("midstall_rst_valid", evt_valid, 0);
        check("midstall_rst_ovr", overrun, 0);
        do_reset(4'b1111);
        for (int k = 0; k < 3; k++) period(4'b1111, 1'b0);
        check("restart_idx0", pc[5], 0);
        period(4'b1111, 1'b0);

        setup_stall(4'b1101);
        ovr_clr = 1'b1;
        step();
        check("ovr_clr", overrun, 0);
        ovr_clr = 1'b0;
        repeat (2) step();
        ovr_clr = 1'b1;
        step();
        check("ovr_set_wins", overrun, 1);
        ovr_clr = 1'b0;
        enable = 1'b0;
        evt_ready = 1'b1;
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd2, 1'b1});
        exp_q.push_back({2'd3, 1'b1});
        repeat (2) step();
        check("dis_finish_out", sig_out, 4'b1101);
        check("dis_finish_chan", evt_chan, 3);
        sig_in = 4'b0010;
        repeat (40) step();
        check("dis_no_sweep", sig_out, 4'b1101);
        check("dis_no_tick_ovr", overrun, 1);
        check("dis_idle_valid", evt_valid, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
